line_clear_ctrl: RTL and testbench
==================================

Name: line_clear_ctrl

Overview:
- Controller directly upstream of the board's per-column 12-row register chains.
- Bit r of a chain loads from bit r+1; the top row loads 0; row 0 is the bottom row.
- After a piece locks, the controller scans the board from the bottom row upward and finds full rows.
- It issues one-cycle per-row shift strobes that collapse the rows above each full row downward by one, and it reports the number of lines cleared.

Parameters:
- ROWS, 12, rows per column chain (chain depth).
- COLS, 10, number of column chains.
- SETTLE, 1, cycles to wait after a shift strobe before rescanning (board update latency); legal range 1..7.
- TOTAL_W, 16, width of the running total-lines counter.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: piece locked, begin a clear pass.
- board  in  ROWS*COLS  current board contents; cell (r,c) = board[r*COLS+c].
- shift_en  out  ROWS  one-cycle strobe; bit r high means row r loads row r+1 (top row loads 0).
- busy  out  1  high from the first SCAN cycle through the DONE cycle.
- done  out  1  one-cycle pulse ending a pass.
- lines_cleared  out  $clog2(ROWS+1)  rows cleared in the last pass; valid when done is high, held until the next pass starts.
- total_lines  out  TOTAL_W  saturating running total since reset.

Behaviour:
- Reset: Clk and reset are as already decided; reset is synchronous and active-high. On reset, state=IDLE, row pointer=0, shift_en=0, busy=0, done=0, lines_cleared=0, total_lines=0.
- Reset takes priority over all other inputs, including mid-pass reset. Outputs are zero in the cycle after the reset edge, and any strobe in flight is dropped.
- States: IDLE, SCAN, SHIFT, SETTLE, DONE.
- IDLE:
  - start=1 -> SCAN with ptr=0 and the pass counter cleared to 0.
  - start is ignored in every other state; no queuing.
- SCAN (1 cycle per row): evaluate row ptr as the AND of all its COLS bits.
  - Row full -> SHIFT.
  - Row not full and ptr<ROWS-1 -> ptr+1, stay in SCAN.
  - Row not full and ptr=ROWS-1 -> DONE.
- SHIFT (1 cycle):
  - shift_en[r]=1 for all r>=ptr, 0 otherwise (registered output, high exactly this cycle).
  - Pass counter increments.
  - Go to SETTLE with the settle counter set to SETTLE.
- SETTLE: count down SETTLE cycles with shift_en=0, then return to SCAN with ptr unchanged, so the row that dropped into ptr is rechecked.
- DONE (1 cycle): done=1, lines_cleared=pass count, total_lines += pass count (saturate at 2^TOTAL_W-1), then go to IDLE.
- busy=1 in SCAN, SHIFT, SETTLE and DONE.
- Latency:
  - Empty board, start at edge t: SCAN occupies cycles t+1..t+ROWS; done is high in cycle t+ROWS+1.
  - Each cleared row adds 2+SETTLE cycles (SHIFT, SETTLE, rescan).
- Boundaries:
  - A full top row is cleared by shift_en=1 on bit ROWS-1 only; it loads 0, rescans not full, and the pass ends.
  - Consecutive full rows are cleared by repeated clears at the same ptr.
  - The pass always terminates because each clear removes one full row and zeros enter at the top.
  - Maximum pass count is ROWS (every row full).
- board changing outside SHIFT/SETTLE is not the controller's concern; it samples board only in SCAN.

Decomposition:
- Shared package holds:
  - ROWS/COLS defaults.
  - State enum {IDLE, SCAN, SHIFT, SETTLE, DONE}.
  - The width function for lines_cleared.
- One natural sub-module: row_full_sel (combinational select of row ptr from board plus AND-reduce, output full).
- The FSM, counters and strobe register stay in line_clear_ctrl.

Test Plan:
- Bench board model: COLS chains of ROWS bits that shift on shift_en with top input 0, updating one cycle after the strobe.
- Empty board, start -> no shift_en, done in cycle t+13, lines_cleared=0, total_lines=0.
- Row 0 full, row 1 = 0b1010000001, rest empty, start:
  - shift_en=12'hFFF for exactly 1 cycle.
  - Afterwards row 0 = 0b1010000001 and row 1 = 0.
  - lines_cleared=1; done at t+16 with SETTLE=1.
- Rows 0,1,2,5 full:
  - shift_en=12'hFFF three times, then 12'hFFC once.
  - lines_cleared=4 and total_lines=4; a second identical pass gives total_lines=8.
- Only row 11 full -> single strobe 12'h800, row 11 becomes 0, lines_cleared=1.
- start re-pulsed while busy (during SETTLE) -> ignored; exactly one done; lines_cleared unchanged versus a single pulse.
- reset asserted in the SHIFT cycle:
  - The next cycle has shift_en=0, busy=0, total_lines=0, state IDLE.
  - A new start then completes a normal pass.

Source files
------------

// File: rtl/line_clear_ctrl_pkg.sv
// Shared types and defaults for the line clear controller.
// State encoding, board geometry defaults and width helpers.
package line_clear_ctrl_pkg;

  localparam int ROWS_DEF = 12;
  localparam int COLS_DEF = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SHIFT,
    S_SETTLE,
    S_DONE
  } lc_state_t;

  // Width of a count that must hold 0..rows.
  function automatic int lc_width(input int rows);
    return $clog2(rows + 1);
  endfunction

  // Width of a row pointer (at least one bit).
  function automatic int ptr_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/line_clear_ctrl_row_full_sel.sv
// Selects row ptr of the board and reports whether every cell is set.
// Ports: board (ROWS*COLS), ptr (row index) -> full.
module row_full_sel
  import line_clear_ctrl_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int PTR_W = ptr_width(ROWS)
) (
  input  logic [ROWS*COLS-1:0] board,
  input  logic [PTR_W-1:0]     ptr,
  output logic                 full
);

  // Plain mux over rows keeps the index arithmetic constant.
  always_comb begin
    full = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (ptr == PTR_W'(r)) begin
        full = &board[r*COLS +: COLS];
      end
    end
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// Scans the board bottom-up after a lock and collapses full rows.
// Ports: Clk, reset, start, board -> shift_en, busy, done,
//        lines_cleared, total_lines.
module line_clear_ctrl
  import line_clear_ctrl_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int SETTLE  = 1,
  parameter int TOTAL_W = 16,
  localparam int LC_W   = lc_width(ROWS)
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] board,
  output logic [ROWS-1:0]      shift_en,
  output logic                 busy,
  output logic                 done,
  output logic [LC_W-1:0]      lines_cleared,
  output logic [TOTAL_W-1:0]   total_lines
);

  localparam int PTR_W = ptr_width(ROWS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(ROWS - 1);
  localparam logic [TOTAL_W-1:0] TMAX = '1;

  lc_state_t         state;
  logic [PTR_W-1:0]  ptr;
  logic [LC_W-1:0]   pass_cnt;
  logic [2:0]        settle_cnt;
  logic              full;
  logic [ROWS-1:0]   mask;
  logic [TOTAL_W:0]  sum;
  logic [TOTAL_W-1:0] total_nxt;

  row_full_sel #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .PTR_W (PTR_W)
  ) u_sel (
    .board (board),
    .ptr   (ptr),
    .full  (full)
  );

  // Rows at and above ptr drop by one.
  always_comb begin
    mask = '0;
    for (int r = 0; r < ROWS; r++) begin
      mask[r] = (r >= int'(ptr));
    end
  end

  always_comb begin
    sum = {1'b0, total_lines} + (TOTAL_W+1)'(pass_cnt);
    total_nxt = sum[TOTAL_W] ? TMAX : sum[TOTAL_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ptr           <= '0;
      pass_cnt      <= '0;
      settle_cnt    <= '0;
      shift_en      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
      total_lines   <= '0;
    end else begin
      shift_en <= '0;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SCAN;
            ptr      <= '0;
            pass_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        S_SCAN: begin
          if (full) begin
            state    <= S_SHIFT;
            shift_en <= mask;
          end else if (ptr == LAST) begin
            state         <= S_DONE;
            done          <= 1'b1;
            lines_cleared <= pass_cnt;
            total_lines   <= total_nxt;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_SHIFT: begin
          pass_cnt   <= pass_cnt + 1'b1;
          settle_cnt <= 3'(SETTLE);
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          // ptr is kept so the row that fell into it is rechecked.
          if (settle_cnt <= 3'd1) begin
            state <= S_SCAN;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl.
// Board model shifts on shift_en; reference computed from clear rules.
module tb_line_clear_ctrl;

  localparam int ROWS    = 12;
  localparam int COLS    = 10;
  localparam int SETTLE  = 1;
  localparam int TOTAL_W = 16;
  localparam int LC_W    = $clog2(ROWS + 1);
  localparam int N       = ROWS * COLS;

  logic               Clk = 1'b0;
  logic               reset;
  logic               start;
  logic [N-1:0]       board;
  logic [ROWS-1:0]    shift_en;
  logic               busy;
  logic               done;
  logic [LC_W-1:0]    lines_cleared;
  logic [TOTAL_W-1:0] total_lines;

  line_clear_ctrl #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .SETTLE  (SETTLE),
    .TOTAL_W (TOTAL_W)
  ) dut (
    .Clk           (Clk),
    .reset         (reset),
    .start         (start),
    .board         (board),
    .shift_en      (shift_en),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .total_lines   (total_lines)
  );

  always #5 Clk = ~Clk;

  // Board model: column chains, top row loads zero.
  logic         tb_load;
  logic [N-1:0] tb_val;

  always @(posedge Clk) begin
    logic [N+COLS-1:0] ext;
    logic [N-1:0]      nxt;
    ext = {{COLS{1'b0}}, board};
    nxt = board;
    for (int r = 0; r < ROWS; r++)
      if (shift_en[r]) nxt[r*COLS +: COLS] = ext[(r+1)*COLS +: COLS];
    if (tb_load) board <= tb_val;
    else board <= nxt;
  end

  int checks = 0;
  int errors = 0;
  int exp_total = 0;

  logic [ROWS-1:0] got_q[$];
  logic [ROWS-1:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [COLS-1:0] row_of(input logic [N-1:0] b, input int r);
    return b[r*COLS +: COLS];
  endfunction

  function automatic logic [N-1:0] mk(input logic [ROWS-1:0] fullrows);
    logic [N-1:0] b;
    b = '0;
    for (int r = 0; r < ROWS; r++)
      if (fullrows[r]) b[r*COLS +: COLS] = '1;
    return b;
  endfunction

  // Reference: each full row is removed; the strobe base is the
  // number of surviving rows below it; survivors pack downward.
  task automatic ref_model(input logic [N-1:0] b, output int lines,
                           output int lat, output logic [N-1:0] fin);
    int kept;
    logic [ROWS-1:0] m;
    kept = 0;
    lines = 0;
    fin = '0;
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      if (&row_of(b, r)) begin
        m = '1;
        m = m << kept;
        exp_q.push_back(m);
        lines++;
      end else begin
        fin[kept*COLS +: COLS] = row_of(b, r);
        kept++;
      end
    end
    lat = ROWS + 1 + lines * (2 + SETTLE);
  endtask

  // One full pass with reference checks; optional start re-pulse.
  task automatic do_pass(input logic [N-1:0] init, input int repulse_at,
                         output int lat, output int lines,
                         output logic [ROWS-1:0] first_m,
                         output logic [ROWS-1:0] last_m);
    int r_lines, r_lat, busy_bad;
    logic [N-1:0] r_fin;
    ref_model(init, r_lines, r_lat, r_fin);
    got_q.delete();
    busy_bad = 0;
    lat = -1;
    lines = -1;
    @(negedge Clk);
    tb_load = 1'b1;
    tb_val = init;
    @(negedge Clk);
    tb_load = 1'b0;
    start = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge Clk);
      start = (n == repulse_at);
      if (shift_en != '0) got_q.push_back(shift_en);
      if (!busy) busy_bad++;
      if (done) begin
        lat = n;
        lines = int'(lines_cleared);
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) chk("pass_timeout", 0, 1);
    if (r_lines > 0) exp_total = exp_total + r_lines;
    if (exp_total > 65535) exp_total = 65535;
    chk("latency", lat, r_lat);
    chk("lines_cleared", lines, r_lines);
    chk("total_lines", total_lines, exp_total);
    chk("busy_in_pass", busy_bad, 0);
    chk("strobe_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("strobe_mask", got_q[i], exp_q[i]);
    chk("final_board", board, r_fin);
    first_m = (got_q.size() > 0) ? got_q[0] : '0;
    last_m = (got_q.size() > 0) ? got_q[got_q.size()-1] : '0;
    @(negedge Clk);
    chk("busy_after", busy, 0);
    chk("done_pulse", done, 0);
  endtask

  typedef struct {
    logic [N-1:0]    bd;
    int              lines;
    int              lat;
    int              total;
    logic [ROWS-1:0] first_m;
    logic [ROWS-1:0] last_m;
  } vec_t;

  vec_t vt[6];

  initial begin
    int lat, lines, seen;
    logic [ROWS-1:0] fm, lm;
    logic [N-1:0] b;

    vt[0] = '{mk(12'h000), 0, 13, 0, 12'h000, 12'h000};
    vt[1] = '{mk(12'h027), 4, 25, 4, 12'hFFF, 12'hFFC};
    vt[2] = '{mk(12'h027), 4, 25, 8, 12'hFFF, 12'hFFC};
    b = mk(12'h001);
    b[COLS +: COLS] = 10'b1010000001;
    vt[3] = '{b, 1, 16, 9, 12'hFFF, 12'hFFF};
    vt[4] = '{mk(12'h800), 1, 16, 10, 12'h800, 12'h800};
    vt[5] = '{mk(12'hFFF), 12, 49, 22, 12'hFFF, 12'hFFF};

    reset = 1'b1;
    start = 1'b0;
    tb_load = 1'b1;
    tb_val = '0;
    repeat (3) @(negedge Clk);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lines", lines_cleared, 0);
    chk("rst_total", total_lines, 0);
    reset = 1'b0;
    tb_load = 1'b0;

    foreach (vt[i]) begin
      do_pass(vt[i].bd, 0, lat, lines, fm, lm);
      chk("tbl_lat", lat, vt[i].lat);
      chk("tbl_lines", lines, vt[i].lines);
      chk("tbl_total", total_lines, vt[i].total);
      chk("tbl_first", fm, vt[i].first_m);
      chk("tbl_last", lm, vt[i].last_m);
    end
    chk("row0_after", row_of(board, 0), 10'b0);

    b = mk(12'h001);
    b[COLS +: COLS] = 10'b1010000001;
    do_pass(b, 0, lat, lines, fm, lm);
    chk("row0_keep", row_of(board, 0), 10'b1010000001);
    chk("row1_zero", row_of(board, 1), 0);

    // start re-pulsed during SETTLE is ignored
    do_pass(b, 3, lat, lines, fm, lm);
    chk("repulse_lines", lines, 1);
    chk("repulse_lat", lat, 16);
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge Clk);
      if (done || busy) seen++;
    end
    chk("repulse_one_done", seen, 0);

    // reset in the SHIFT cycle
    @(negedge Clk);
    tb_load = 1'b1;
    tb_val = mk(12'h001);
    @(negedge Clk);
    tb_load = 1'b0;
    start = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clk);
      start = 1'b0;
      if (shift_en != '0) begin
        seen = 1;
        break;
      end
    end
    chk("shift_seen", seen, 1);
    reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_shift", shift_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_total", total_lines, 0);
    chk("mid_rst_done", done, 0);
    reset = 1'b0;
    exp_total = 0;
    do_pass(mk(12'h003), 0, lat, lines, fm, lm);

    // randomized boards against the reference
    for (int k = 0; k < 30; k++) begin
      b = '0;
      for (int r = 0; r < ROWS; r++) begin
        if ($urandom_range(0, 2) == 0) b[r*COLS +: COLS] = '1;
        else b[r*COLS +: COLS] = COLS'($urandom);
      end
      do_pass(b, 0, lat, lines, fm, lm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
